mem_port_arbiter: RTL and testbench

Shares the single cache-side memory port between up to `NumReq` requesters: instruction-cache refill, data-cache miss unit, data-cache write buffer.
- Issues one request per accepted handshake through a registered output stage.
- Tags each request with the requester index so responses can be routed back.
- Bounds in-flight transactions with an outstanding counter.
- Sits between the cache subsystem and the AXI adapter in the write-through cache configuration.

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one cache-side memory port between NumReq requesters. The winner of
// each accepted handshake is captured in a registered output stage. Its id is
// the requester index concatenated with the requester's tid, so the response
// path can steer data back. An outstanding counter limits in-flight traffic.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins). By default arbitration is round-robin.
module mem_port_arbiter #(
   parameter int unsigned NumReq         = 3,
   parameter int unsigned AddrWidth      = 34,
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned TidWidth       = 2,
   parameter int unsigned MaxOutstanding = 4,
   localparam int unsigned IdxW          = (NumReq > 2) ? $clog2(NumReq) : 1,
   localparam int unsigned IdW           = TidWidth + IdxW
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumReq-1:0]             req_valid_i,
   output logic [NumReq-1:0]             req_ready_o,
   input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
   input  logic [NumReq-1:0]             req_we_i,
   input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
   input  logic [NumReq*TidWidth-1:0]    req_tid_i,
   output logic                          mem_req_valid_o,
   input  logic                          mem_req_ready_i,
   output logic [AddrWidth-1:0]          mem_req_addr_o,
   output logic                          mem_req_we_o,
   output logic [DataWidth-1:0]          mem_req_wdata_o,
   output logic [IdW-1:0]                mem_req_id_o,
   input  logic                          mem_rsp_valid_i,
   input  logic [IdW-1:0]                mem_rsp_id_i,
   input  logic [DataWidth-1:0]          mem_rsp_data_i,
   output logic [NumReq-1:0]             rsp_valid_o,
   output logic [TidWidth-1:0]           rsp_tid_o,
   output logic [DataWidth-1:0]          rsp_data_o,
   output logic                          id_err_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   typedef enum logic {
      EMPTY,
      FULL
   } state_t;

   state_t               state_q;
   logic [AddrWidth-1:0] addr_q;
   logic                 we_q;
   logic [DataWidth-1:0] wdata_q;
   logic [IdW-1:0]       id_q;
   logic [CntW-1:0]      cnt_q;
   logic                 err_q;

   logic [IdxW-1:0]      win;
   logic                 win_any;
   logic                 load;
   logic                 hs;
   logic [IdxW-1:0]      rsp_idx;
   logic                 rsp_in_range;
   logic                 rsp_legal;

`ifdef MEM_ARB_FIXED_PRIO_EN
   // Fixed priority: the lowest-indexed valid requester wins.
   always_comb begin
      win     = '0;
      win_any = 1'b0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         if (!win_any && req_valid_i[i]) begin
            win_any = 1'b1;
            win     = IdxW'(i);
         end
      end
   end
`else
   logic [IdxW-1:0] rr_q;

   // Round-robin: first valid requester found scanning upward from rr_q.
   always_comb begin
      int unsigned scan;
      scan    = 0;
      win     = '0;
      win_any = 1'b0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         scan = (32'(rr_q) + i) % NumReq;
         if (!win_any && req_valid_i[scan]) begin
            win_any = 1'b1;
            win     = IdxW'(scan);
         end
      end
   end
`endif

   // Load when the stage is free or draining this cycle and the counter has room.
   assign load = ((state_q == EMPTY) || mem_req_ready_i)
               && (cnt_q < CntW'(MaxOutstanding))
               && win_any;
   assign hs   = (state_q == FULL) && mem_req_ready_i;

   // Single-hot accept strobe towards the winning requester.
   always_comb begin
      req_ready_o = '0;
      if (load) begin
         req_ready_o[win] = 1'b1;
      end
   end

   // Output stage FSM with registered request fields and arbitration pointer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         id_q    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         rr_q    <= '0;
`endif
      end else begin
         if (load) begin
            state_q <= FULL;
            addr_q  <= req_addr_i[32'(win)*AddrWidth +: AddrWidth];
            we_q    <= req_we_i[win];
            wdata_q <= req_wdata_i[32'(win)*DataWidth +: DataWidth];
            id_q    <= {win, req_tid_i[32'(win)*TidWidth +: TidWidth]};
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_q    <= IdxW'((32'(win) + 1) % NumReq);
`endif
         end else if (hs) begin
            state_q <= EMPTY;
         end
      end
   end

   assign mem_req_valid_o = (state_q == FULL);
   assign mem_req_addr_o  = addr_q;
   assign mem_req_we_o    = we_q;
   assign mem_req_wdata_o = wdata_q;
   assign mem_req_id_o    = id_q;

   assign rsp_idx      = mem_rsp_id_i[IdW-1:TidWidth];
   assign rsp_in_range = (32'(rsp_idx) < NumReq);
   assign rsp_legal    = mem_rsp_valid_i && rsp_in_range && (cnt_q != '0);

   // Outstanding counter; a bad response never decrements and flags an error.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         case ({hs, rsp_legal})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (mem_rsp_valid_i && !rsp_legal) begin
            err_q <= 1'b1;
         end
      end
   end

   assign id_err_o = err_q;

   // Zero-latency response steering by requester index.
   always_comb begin
      rsp_valid_o = '0;
      if (mem_rsp_valid_i && rsp_in_range) begin
         rsp_valid_o[rsp_idx] = 1'b1;
      end
   end

   assign rsp_tid_o  = mem_rsp_id_i[TidWidth-1:0];
   assign rsp_data_o = mem_rsp_data_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (default parameters).
// A reference model at the falling edge predicts grants, and a scoreboard
// queue holds expected issued requests. Honours MEM_ARB_FIXED_PRIO_EN.
module tb_mem_port_arbiter;
   localparam int NR   = 3;
   localparam int AW   = 34;
   localparam int DW   = 64;
   localparam int TW   = 2;
   localparam int IDW  = 4;
   localparam int MAXO = 4;

   logic                clk_i;
   logic                rst_ni;
   logic [NR-1:0]       req_valid_i;
   logic [NR-1:0]       req_ready_o;
   logic [NR*AW-1:0]    req_addr_i;
   logic [NR-1:0]       req_we_i;
   logic [NR*DW-1:0]    req_wdata_i;
   logic [NR*TW-1:0]    req_tid_i;
   logic                mem_req_valid_o;
   logic                mem_req_ready_i;
   logic [AW-1:0]       mem_req_addr_o;
   logic                mem_req_we_o;
   logic [DW-1:0]       mem_req_wdata_o;
   logic [IDW-1:0]      mem_req_id_o;
   logic                mem_rsp_valid_i;
   logic [IDW-1:0]      mem_rsp_id_i;
   logic [DW-1:0]       mem_rsp_data_i;
   logic [NR-1:0]       rsp_valid_o;
   logic [TW-1:0]       rsp_tid_o;
   logic [DW-1:0]       rsp_data_o;
   logic                id_err_o;

   mem_port_arbiter #(
      .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW), .MaxOutstanding(MAXO)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_we_i(req_we_i),
      .req_wdata_i(req_wdata_i), .req_tid_i(req_tid_i),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_req_addr_o(mem_req_addr_o), .mem_req_we_o(mem_req_we_o),
      .mem_req_wdata_o(mem_req_wdata_o), .mem_req_id_o(mem_req_id_o),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_id_i(mem_rsp_id_i),
      .mem_rsp_data_i(mem_rsp_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_tid_o(rsp_tid_o), .rsp_data_o(rsp_data_o),
      .id_err_o(id_err_o)
   );

   typedef struct {
      logic [AW-1:0]  addr;
      logic           we;
      logic [DW-1:0]  wdata;
      logic [IDW-1:0] id;
   } txn_t;

   int num_checks = 0;
   int num_errors = 0;

   // stimulus state (written by the main process only)
   logic [AW-1:0] r_addr  [NR];
   logic          r_we    [NR];
   logic [DW-1:0] r_wdata [NR];
   logic [TW-1:0] r_tid   [NR];
   int            left    [NR];
   bit            rsp_auto = 0;
   int            rsp_ptr  = 0;

   // model state (written by the monitor only)
   txn_t           exp_q[$];
   logic [IDW-1:0] inflight[$];
   bit             m_full = 0;
   int unsigned    m_rr   = 0;
   int             m_cnt  = 0;
   bit             m_err  = 0;
   logic [NR-1:0]  got    = '0;
   int unsigned    e_w, start, c;
   bit             e_any, e_load, m_hs, m_legal;
   logic [1:0]     r_idx;
   txn_t           t;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      num_checks++;
      if (act !== exp) begin
         num_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: predict combinational outputs, then advance one cycle.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         m_full = 0; m_rr = 0; m_cnt = 0; m_err = 0; got = '0;
         exp_q.delete();
         check("rst_req_ready", 64'(req_ready_o), 64'(0));
         check("rst_mem_valid", 64'(mem_req_valid_o), 64'(0));
         check("rst_id_err", 64'(id_err_o), 64'(0));
         check("rst_cnt", 64'(dut.cnt_q), 64'(0));
      end else begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         start = 0;
`else
         start = m_rr;
`endif
         e_any = 0; e_w = 0;
         for (int i = 0; i < NR; i++) begin
            c = (start + i) % NR;
            if (!e_any && req_valid_i[c]) begin e_any = 1; e_w = c; end
         end
         e_load = (!m_full || mem_req_ready_i) && (m_cnt < MAXO) && e_any;
         check("req_ready", 64'(req_ready_o), e_load ? (64'(1) << e_w) : 64'(0));
         check("mem_valid", 64'(mem_req_valid_o), 64'(m_full));
         if (m_full && exp_q.size() != 0) begin
            check("mem_addr", 64'(mem_req_addr_o), 64'(exp_q[0].addr));
            check("mem_we", 64'(mem_req_we_o), 64'(exp_q[0].we));
            check("mem_wdata", mem_req_wdata_o, exp_q[0].wdata);
            check("mem_id", 64'(mem_req_id_o), 64'(exp_q[0].id));
         end
         r_idx = mem_rsp_id_i[3:2];
         if (mem_rsp_valid_i) begin
            check("rsp_valid", 64'(rsp_valid_o), (r_idx < NR) ? (64'(1) << r_idx) : 64'(0));
            check("rsp_tid", 64'(rsp_tid_o), 64'(mem_rsp_id_i[1:0]));
            check("rsp_data", rsp_data_o, mem_rsp_data_i);
         end else begin
            check("rsp_idle", 64'(rsp_valid_o), 64'(0));
         end
         check("id_err", 64'(id_err_o), 64'(m_err));
         check("cnt", 64'(dut.cnt_q), 64'(m_cnt));

         m_hs = m_full && mem_req_ready_i;
         if (m_hs && exp_q.size() != 0) begin
            t = exp_q.pop_front();
            inflight.push_back(t.id);
         end
         m_legal = mem_rsp_valid_i && (r_idx < NR) && (m_cnt != 0);
         m_cnt = m_cnt + int'(m_hs) - int'(m_legal);
         if (mem_rsp_valid_i && !m_legal) m_err = 1;
         if (e_load) begin
            t.addr  = req_addr_i[e_w*AW +: AW];
            t.we    = req_we_i[e_w];
            t.wdata = req_wdata_i[e_w*DW +: DW];
            t.id    = {2'(e_w), req_tid_i[e_w*TW +: TW]};
            exp_q.push_back(t);
            m_rr   = (e_w + 1) % NR;
            m_full = 1;
         end else if (m_hs) begin
            m_full = 0;
         end
         got = req_ready_o;
      end
   end

   task automatic apply();
      for (int k = 0; k < NR; k++) begin
         req_valid_i[k]          = (left[k] != 0);
         req_addr_i[k*AW +: AW]  = r_addr[k];
         req_we_i[k]             = r_we[k];
         req_wdata_i[k*DW +: DW] = r_wdata[k];
         req_tid_i[k*TW +: TW]   = r_tid[k];
      end
   endtask

   task automatic new_payload(input int k);
      r_addr[k]  = {2'($urandom_range(3)), 32'($urandom)};
      r_we[k]    = 1'($urandom_range(1));
      r_wdata[k] = {32'($urandom), 32'($urandom)};
      r_tid[k]   = 2'($urandom_range(3));
   endtask

   // One clock: requesters react to grants, then the response channel is driven.
   task automatic cycle(input bit man, input logic [IDW-1:0] man_id);
      @(posedge clk_i);
      #1;
      for (int k = 0; k < NR; k++) begin
         if (got[k] && left[k] != 0) begin
            left[k]--;
            new_payload(k);
         end
      end
      apply();
      mem_rsp_valid_i = 1'b0;
      if (man) begin
         mem_rsp_valid_i = 1'b1;
         mem_rsp_id_i    = man_id;
      end else if (rsp_auto && rsp_ptr < inflight.size()) begin
         mem_rsp_valid_i = 1'b1;
         mem_rsp_id_i    = inflight[rsp_ptr];
         rsp_ptr++;
      end
      if (mem_rsp_valid_i) mem_rsp_data_i = {32'($urandom), 32'($urandom)};
   endtask

   task automatic wait_idle(input int budget);
      bit busy;
      busy = 1;
      for (int n = 0; n <= budget; n++) begin
         busy = m_full || (m_cnt != 0) || (rsp_ptr < inflight.size());
         for (int k = 0; k < NR; k++) if (left[k] != 0) busy = 1;
         if (!busy) break;
         cycle(0, '0);
      end
      check("drain", 64'(busy), 64'(0));
   endtask

   logic [AW-1:0] held_addr;

   initial begin
      rst_ni = 1'b0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_id_i    = '0;
      mem_rsp_data_i  = '0;
      for (int k = 0; k < NR; k++) begin left[k] = 0; new_payload(k); end
      apply();
      repeat (3) cycle(0, '0);
      #2;
      check("rst_addr", 64'(mem_req_addr_o), 64'(0));
      check("rst_id", 64'(mem_req_id_o), 64'(0));
      rst_ni = 1'b1;
      cycle(0, '0);

      // single request from requester 1
      r_addr[1] = 34'h0_8000_0040; r_tid[1] = 2'd2; r_we[1] = 1'b0;
      left[1] = 1; mem_req_ready_i = 1'b1; rsp_auto = 1;
      apply();
      #2 check("t1_ready", 64'(req_ready_o), 64'(3'b010));
      cycle(0, '0);
      #2 check("t1_id", 64'(mem_req_id_o), 64'(4'b0110));
      check("t1_addr", 64'(mem_req_addr_o), 64'h0_8000_0040);
      cycle(0, '0);
      #2 check("t1_cnt", 64'(dut.cnt_q), 64'(1));
      wait_idle(20);

      // all requesters continuously valid, memory always ready
      for (int k = 0; k < NR; k++) left[k] = 6;
      apply();
      wait_idle(200);

      // memory stalls while the stage is full
      mem_req_ready_i = 1'b0;
      left[0] = 2; left[2] = 2;
      apply();
      cycle(0, '0);
      #2 held_addr = mem_req_addr_o;
      repeat (5) begin
         cycle(0, '0);
         #2 check("stall_ready", 64'(req_ready_o), 64'(0));
         check("stall_addr", 64'(mem_req_addr_o), 64'(held_addr));
      end
      mem_req_ready_i = 1'b1;
      wait_idle(50);

      // throttle at MaxOutstanding
      rsp_auto = 0;
      left[0] = 4;
      apply();
      for (int n = 0; n < 20 && (left[0] != 0 || m_full); n++) cycle(0, '0);
      #2 check("thr_cnt", 64'(dut.cnt_q), 64'(4));
      left[2] = 1;
      apply();
      repeat (3) begin
         #2 check("thr_blocked", 64'(req_ready_o), 64'(0));
         cycle(0, '0);
      end
      cycle(1, 4'b0001);
      #2 check("thr_rsp_valid", 64'(rsp_valid_o), 64'(3'b001));
      check("thr_rsp_tid", 64'(rsp_tid_o), 64'(1));
      check("thr_no_bypass", 64'(req_ready_o), 64'(0));
      cycle(0, '0);
      #2 check("thr_release", 64'(req_ready_o), 64'(3'b100));
      cycle(0, '0);
      cycle(0, '0);

      // out-of-range response index
      cycle(1, 4'b1100);
      #2 check("bad_rsp_valid", 64'(rsp_valid_o), 64'(0));
      cycle(0, '0);
      #2 check("bad_err", 64'(id_err_o), 64'(1));
      check("bad_cnt", 64'(dut.cnt_q), 64'(4));
      cycle(0, '0);
      #2 check("err_sticky", 64'(id_err_o), 64'(1));

      // simultaneous issue and response at cnt 2
      cycle(1, 4'b0001);
      cycle(1, 4'b1001);
      cycle(0, '0);
      #2 check("sim_cnt_pre", 64'(dut.cnt_q), 64'(2));
      left[1] = 1;
      apply();
      cycle(1, 4'b0100);
      #2 check("sim_hs", 64'(mem_req_valid_o & mem_req_ready_i), 64'(1));
      cycle(0, '0);
      #2 check("sim_cnt_post", 64'(dut.cnt_q), 64'(2));
      rsp_ptr  = inflight.size() - 2;
      rsp_auto = 1;
      wait_idle(50);

      // reset with transactions in flight
      rsp_auto = 0;
      left[0] = 2;
      apply();
      repeat (4) cycle(0, '0);
      rst_ni = 1'b0;
      #2 check("mid_rst_valid", 64'(mem_req_valid_o), 64'(0));
      check("mid_rst_cnt", 64'(dut.cnt_q), 64'(0));
      check("mid_rst_err", 64'(id_err_o), 64'(0));
      cycle(0, '0);
      cycle(0, '0);
      rst_ni = 1'b1;
      rsp_ptr = inflight.size();
      cycle(1, inflight[inflight.size()-1]);
      cycle(0, '0);
      #2 check("stale_rsp_err", 64'(id_err_o), 64'(1));
      cycle(0, '0);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end
endmodule
